// File: rtl/l2_pkg.sv
// Shared constants and state encoding for the L2 line <-> burst memory adaptor.
// Also used by the L2 controller bench.
package l2_pkg;

  localparam int S_OFFSET = 5;
  localparam int S_LINE   = 256;
  localparam int S_BURST  = 64;
  localparam int BEATS    = S_LINE / S_BURST;
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/l2_cacheline_adaptor.sv
// Converts one 256-bit L2 line request into a 4-beat 64-bit burst to memory
// and returns a single-cycle line_resp when the burst completes.
module l2_cacheline_adaptor
  import l2_pkg::*;
#(
  parameter int s_offset = S_OFFSET,
  parameter int s_line   = S_LINE,
  parameter int s_burst  = S_BURST
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [31:0]        line_address,
  input  logic [s_line-1:0]  line_wdata,
  output logic [s_line-1:0]  line_rdata,
  output logic               line_resp,
  output logic               burst_read,
  output logic               burst_write,
  output logic [31:0]        burst_address,
  output logic [s_burst-1:0] burst_wdata,
  input  logic [s_burst-1:0] burst_rdata,
  input  logic               burst_resp
);

  localparam int NBEATS = s_line / s_burst;
  localparam int CW     = $clog2(NBEATS);
  localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

  adaptor_state_t    state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [s_line-1:0] wline_q, wline_d;
  logic [s_line-1:0] rline_q, rline_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        // Read has priority when both requests are raised together.
        if (line_read) begin
          addr_d  = {line_address[31:s_offset], {s_offset{1'b0}}};
          state_d = RD_BURST;
        end else if (line_write) begin
          addr_d  = {line_address[31:s_offset], {s_offset{1'b0}}};
          wline_d = line_wdata;
          state_d = WR_BURST;
        end
      end
      RD_BURST: begin
        if (burst_resp) begin
          rline_d[cnt_q*s_burst +: s_burst] = burst_rdata;
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      WR_BURST: begin
        if (burst_resp) begin
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    burst_read    = (state_q == RD_BURST);
    burst_write   = (state_q == WR_BURST);
    burst_address = addr_q;
    burst_wdata   = '0;
    if (state_q == WR_BURST) burst_wdata = wline_q[cnt_q*s_burst +: s_burst];
    line_resp     = (state_q == DONE);
    line_rdata    = rline_q;
  end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Randomized self-checking bench: acts as burst memory and compares against a line-level model.
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         reset;
  logic         line_read, line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read, burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int ncmp  = 0;
  int nfail = 0;
  logic [255:0] exp_rdata;

  l2_cacheline_adaptor dut (
    .clk(clk), .reset(reset),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd64(), rnd64(), rnd64(), rnd64()};
  endfunction

  // Called at a negedge in an IDLE cycle (or in DONE when from_done is set).
  // mode: 0 random gaps, 1 back-to-back beats, 2 fixed pattern 1,0,0,1,1,0,1.
  // Returns at the negedge of the DONE cycle with line_resp checked.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wd, input int mode, input bit from_done);
    logic         exp_rd, exp_wr, fire;
    logic [31:0]  exp_addr;
    logic [255:0] nl;
    logic [6:0]   pat;
    int beat, idx;
    pat = 7'b1011001;
    line_read = rd; line_write = wr; line_address = addr; line_wdata = wd;
    burst_resp = from_done;  // stray strobe while idle must be ignored
    if (from_done) begin
      @(negedge clk);
      chk("idle_resp", line_resp, 0);
      chk("idle_bread", burst_read, 0);
      chk("idle_bwrite", burst_write, 0);
      burst_resp = 1'b0;
    end
    exp_rd = rd; exp_wr = wr & ~rd;
    exp_addr = {addr[31:5], 5'b0};
    nl = exp_rdata; beat = 0; idx = 0;
    while (beat < 4) begin
      @(negedge clk);
      if (idx >= 100) begin
        chk("burst_timeout", beat, 4);
        break;
      end
      chk("burst_read", burst_read, exp_rd);
      chk("burst_write", burst_write, exp_wr);
      chk("burst_address", burst_address, exp_addr);
      chk("early_resp", line_resp, 0);
      if (exp_wr) chk("burst_wdata", burst_wdata, wd[beat*64 +: 64]);
      fire = (mode == 1) ? 1'b1 : (mode == 2) ? pat[idx % 7] : ($urandom_range(99) >= 40);
      idx++;
      burst_resp  = fire;
      burst_rdata = rnd64();
      if (fire) begin
        nl[beat*64 +: 64] = burst_rdata;
        beat++;
      end
      line_address = $urandom;
      line_wdata   = rnd256();
    end
    @(negedge clk);
    burst_resp = 1'b0;
    burst_rdata = rnd64();
    if (exp_rd) exp_rdata = nl;
    chk("line_resp", line_resp, 1);
    chk("done_bread", burst_read, 0);
    chk("done_bwrite", burst_write, 0);
    chk("line_rdata", line_rdata, exp_rdata);
  endtask

  // Drop the request at DONE and spend one idle cycle checking quiescence.
  task automatic idle_gap();
    line_read = 1'b0; line_write = 1'b0;
    burst_resp = 1'($urandom_range(1));
    @(negedge clk);
    burst_resp = 1'b0;
    chk("gap_resp", line_resp, 0);
    chk("gap_bread", burst_read, 0);
    chk("gap_bwrite", burst_write, 0);
    chk("gap_rdata", line_rdata, exp_rdata);
  endtask

  initial begin
    logic [255:0] wl;
    int k;
    reset = 1'b1; line_read = 0; line_write = 0; line_address = '0; line_wdata = '0;
    burst_rdata = '0; burst_resp = 0; exp_rdata = '0;
    #2;
    chk("rst_resp", line_resp, 0);
    chk("rst_bread", burst_read, 0);
    chk("rst_bwrite", burst_write, 0);
    chk("rst_baddr", burst_address, 0);
    chk("rst_bwdata", burst_wdata, 0);
    chk("rst_rdata", line_rdata, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // Directed read with the reference beat values
    line_read = 1; line_address = 32'h0000_1234;
    @(negedge clk);
    chk("rd_baddr", burst_address, 32'h0000_1220);
    for (int b = 0; b < 4; b++) begin
      chk("rd_bread", burst_read, 1);
      burst_resp = 1; burst_rdata = {8{8'((b + 1) * 8'h11)}};
      @(negedge clk);
    end
    burst_resp = 0;
    exp_rdata = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    chk("rd_resp", line_resp, 1);
    chk("rd_line", line_rdata, exp_rdata);
    idle_gap();
    chk("rd_single_pulse", line_resp, 0);

    // Directed write A,B,C,D
    wl = {64'hD, 64'hC, 64'hB, 64'hA};
    run_req(1'b0, 1'b1, 32'h0000_4000, wl, 1, 1'b0);
    idle_gap();

    // Gapped beats
    run_req(1'b1, 1'b0, $urandom, rnd256(), 2, 1'b0);
    idle_gap();

    // Simultaneous read and write: read wins
    run_req(1'b1, 1'b1, $urandom, rnd256(), 0, 1'b0);
    idle_gap();

    // Reset after two read beats
    line_read = 1; line_address = 32'hABCD_0047;
    @(negedge clk);
    burst_resp = 1; burst_rdata = rnd64();
    @(negedge clk);
    burst_rdata = rnd64();
    @(negedge clk);
    burst_resp = 0;
    chk("pre_rst_bread", burst_read, 1);
    reset = 1'b1; line_read = 0;
    #1;
    chk("mid_rst_bread", burst_read, 0);
    chk("mid_rst_rdata", line_rdata, 0);
    chk("mid_rst_baddr", burst_address, 0);
    chk("mid_rst_resp", line_resp, 0);
    exp_rdata = '0;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_resp", line_resp, 0);
      chk("post_rst_bread", burst_read, 0);
    end
    run_req(1'b1, 1'b0, $urandom, rnd256(), 0, 1'b0);
    idle_gap();

    // Back-to-back: write then read, read raised straight from DONE
    run_req(1'b0, 1'b1, $urandom, rnd256(), 0, 1'b0);
    run_req(1'b1, 1'b0, $urandom, rnd256(), 0, 1'b1);
    idle_gap();

    // Random mix
    for (int t = 0; t < 12; t++) begin
      k = $urandom_range(2);
      run_req(k != 1, k != 0, $urandom, rnd256(), $urandom_range(1), 1'b0);
      idle_gap();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
